avalon_hex_display: RTL and testbench

Parametrised Avalon-MM slave driving NUM_DIGITS active-low 7-segment digits from one register block. It replaces one-PIO-per-digit instances. Each digit is either a raw segment pattern or a hex nibble decoded in hardware. Per-digit blinking is timed by a programmable prescaler. It sits on the Nios II data master bus, and out_port goes straight to the board HEX pins.

---
 rtl/avalon_hex_display.sv | 176 +++++++++++++++++
 tb/tb_avalon_hex_display.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_hex_display.sv
// Avalon-MM slave that drives NUM_DIGITS active-low 7-segment digits, each either raw or hex-decoded, with per-digit blinking.
// Build option: define HEX_DECODE_EN to include the hex decoder and the DECODE_MASK register.

module avalon_hex_display #(
  parameter int         NUM_DIGITS    = 6,
  parameter int         ADDR_W        = 4,
  parameter logic [7:0] RESET_PATTERN = 8'hFF,
  parameter int         PERIOD_W      = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic                    read_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [NUM_DIGITS*8-1:0] out_port
);

  localparam logic [ADDR_W-1:0] ADDR_DECODE = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] ADDR_BLINK  = ADDR_W'(9);
  localparam logic [ADDR_W-1:0] ADDR_PERIOD = ADDR_W'(10);
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(11);

  logic                    w_wr;
  logic                    w_rd;
  logic                    w_period_wr;
  logic                    w_unused;
  logic [7:0]              r_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   r_blink_mask;
  logic [NUM_DIGITS-1:0]   w_decode_mask;
  logic [PERIOD_W-1:0]     r_period;
  logic [PERIOD_W-1:0]     r_cnt;
  logic                    r_phase;
  logic [31:0]             r_readdata;
  logic [31:0]             w_rd_value;
  logic [NUM_DIGITS*8-1:0] r_out_port;
  logic [NUM_DIGITS*8-1:0] w_out_next;
  logic [7:0]              w_seg [NUM_DIGITS];

  assign w_wr        = chipselect & ~write_n;
  assign w_rd        = chipselect & ~read_n;
  assign w_period_wr = w_wr && (address == ADDR_PERIOD);
  // Upper writedata bits beyond each field are intentionally dropped.
  assign w_unused    = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_digit[i] <= RESET_PATTERN;
      end
      r_blink_mask <= '0;
      r_period     <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (address == ADDR_W'(i)) begin
          r_digit[i] <= writedata[7:0];
        end
      end
      if (address == ADDR_BLINK) begin
        r_blink_mask <= writedata[NUM_DIGITS-1:0];
      end
      if (address == ADDR_PERIOD) begin
        r_period <= writedata[PERIOD_W-1:0];
      end
    end
  end

`ifdef HEX_DECODE_EN
  logic [NUM_DIGITS-1:0] r_decode_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_decode_mask <= '0;
    end else if (w_wr && (address == ADDR_DECODE)) begin
      r_decode_mask <= writedata[NUM_DIGITS-1:0];
    end
  end

  assign w_decode_mask = r_decode_mask;

  function automatic logic [6:0] f_hex7(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction
`else
  assign w_decode_mask = '0;
`endif

  // In decode mode DIGIT bit7 is a "dp on" flag, hence the inversion.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
`ifdef HEX_DECODE_EN
    assign w_seg[gi] = w_decode_mask[gi] ? {~r_digit[gi][7], f_hex7(r_digit[gi][3:0])}
                                         : r_digit[gi];
`else
    assign w_seg[gi] = r_digit[gi];
`endif
    assign w_out_next[gi*8 +: 8] = (r_blink_mask[gi] & r_phase) ? 8'hFF : w_seg[gi];
  end

  // A period write restarts the count so a shorter period never has to wrap first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_period_wr) begin
      r_cnt <= '0;
      if (writedata[PERIOD_W-1:0] == '0) begin
        r_phase <= 1'b0;
      end
    end else if (r_period == '0) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == (r_period - PERIOD_W'(1))) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt + PERIOD_W'(1);
    end
  end

  always_comb begin
    w_rd_value = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (address == ADDR_W'(i)) begin
        w_rd_value = {24'b0, r_digit[i]};
      end
    end
    case (address)
      ADDR_DECODE: w_rd_value = 32'(w_decode_mask);
      ADDR_BLINK:  w_rd_value = 32'(r_blink_mask);
      ADDR_PERIOD: w_rd_value = 32'(r_period);
      ADDR_STATUS: w_rd_value = {31'b0, r_phase};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readdata <= '0;
    end else if (w_rd) begin
      r_readdata <= w_rd_value;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_port <= {NUM_DIGITS{RESET_PATTERN}};
    end else begin
      r_out_port <= w_out_next;
    end
  end

  assign readdata = r_readdata;
  assign out_port = r_out_port;

endmodule

// File: tb/tb_avalon_hex_display.sv
// Scoreboarded bench for avalon_hex_display: directed test-plan sequences plus random bus traffic.
// Blink phase is predicted arithmetically from the cycle of the last period write.

module tb_avalon_hex_display;

  localparam int         NUM_DIGITS    = 6;
  localparam int         ADDR_W        = 4;
  localparam int         PERIOD_W      = 24;
  localparam logic [7:0] RESET_PATTERN = 8'hFF;
  localparam int         OUT_W         = NUM_DIGITS * 8;

  logic              clk        = 1'b0;
  logic              reset      = 1'b1;
  logic [ADDR_W-1:0] address    = '0;
  logic              chipselect = 1'b0;
  logic              write_n    = 1'b1;
  logic              read_n     = 1'b1;
  logic [31:0]       writedata  = '0;
  logic [31:0]       readdata;
  logic [OUT_W-1:0]  out_port;

  int errors = 0;
  int checks = 0;

  avalon_hex_display #(
    .NUM_DIGITS(NUM_DIGITS),
    .ADDR_W(ADDR_W),
    .RESET_PATTERN(RESET_PATTERN),
    .PERIOD_W(PERIOD_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .read_n(read_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]          m_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] m_blink;
  logic [PERIOD_W-1:0] m_period;
  int unsigned         m_cyc   = 0;
  int unsigned         m_wedge = 0;
  bit                  m_ph0;
  logic [31:0]         m_rd;
`ifdef HEX_DECODE_EN
  logic [NUM_DIGITS-1:0] m_decode;
  logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
`endif

  typedef struct packed {
    logic [OUT_W-1:0] out;
    logic [31:0]      rd;
  } exp_t;
  exp_t sb_q[$];

  // Phase after edge n: number of full periods since the last period write, mod 2.
  function automatic bit phase_after(int unsigned n);
    int unsigned p;
    p = 32'(m_period);
    if (p == 0) return 1'b0;
    return m_ph0 ^ bit'(((n - m_wedge) / p) % 2);
  endfunction

  function automatic logic [7:0] model_seg(int i);
`ifdef HEX_DECODE_EN
    logic [7:0] h;
    if (m_decode[i]) begin
      h = hex_tbl[m_digit[i][3:0]];
      return {~m_digit[i][7], h[6:0]};
    end
`endif
    return m_digit[i];
  endfunction

  function automatic logic [OUT_W-1:0] model_out(bit ph);
    logic [OUT_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      v[i*8 +: 8] = (m_blink[i] && ph) ? 8'hFF : model_seg(i);
    return v;
  endfunction

  function automatic logic [31:0] model_read(logic [ADDR_W-1:0] a, bit ph);
    if (int'(a) < NUM_DIGITS) return {24'b0, m_digit[a]};
    case (int'(a))
`ifdef HEX_DECODE_EN
      8:  return 32'(m_decode);
`endif
      9:  return 32'(m_blink);
      10: return 32'(m_period);
      11: return {31'b0, ph};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_DIGITS; i++) m_digit[i] = RESET_PATTERN;
`ifdef HEX_DECODE_EN
    m_decode = '0;
`endif
    m_blink  = '0;
    m_period = '0;
    m_ph0    = 1'b0;
    m_wedge  = m_cyc;
    m_rd     = 32'h0;
  endtask

  task automatic model_write(logic [ADDR_W-1:0] a, logic [31:0] d, bit ph);
    if (int'(a) < NUM_DIGITS) begin
      m_digit[a] = d[7:0];
    end else begin
      case (int'(a))
`ifdef HEX_DECODE_EN
        8: m_decode = d[NUM_DIGITS-1:0];
`endif
        9: m_blink = d[NUM_DIGITS-1:0];
        10: begin
          m_period = d[PERIOD_W-1:0];
          m_wedge  = m_cyc;
          m_ph0    = (m_period == '0) ? 1'b0 : ph;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Model process: predicts what the DUT shows after every clock edge.
  initial begin
    exp_t e;
    bit   ph;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        model_reset();
        sb_q.delete();
        e.out = {NUM_DIGITS{RESET_PATTERN}};
        e.rd  = 32'h0;
        sb_q.push_back(e);
      end else begin
        ph    = phase_after(m_cyc);
        e.out = model_out(ph);
        if (chipselect && !read_n) m_rd = model_read(address, ph);
        m_cyc++;
        if (chipselect && !write_n) model_write(address, writedata, ph);
        e.rd = m_rd;
        sb_q.push_back(e);
      end
    end
  end

  // Monitor process: compares DUT outputs mid-cycle against the oldest prediction.
  initial begin
    exp_t me;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        me = sb_q.pop_front();
        check("out_port", 64'(out_port), 64'(me.out));
        check("readdata", 64'(readdata), 64'(me.rd));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic bus(input bit cs, input bit wr, input bit rd,
                     input logic [ADDR_W-1:0] a, input logic [31:0] d);
    chipselect = cs;
    write_n    = !wr;
    read_n     = !rd;
    address    = a;
    writedata  = d;
    $display("txn t=%0t cs=%0b wr=%0b rd=%0b addr=%0d data=%08h", $time, cs, wr, rd, a, d);
    @(posedge clk); #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_n     = 1'b1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    bus(1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    bus(1'b1, 1'b0, 1'b1, a, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) rd(ADDR_W'(a));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset_out_port", 64'(out_port), 64'({NUM_DIGITS{RESET_PATTERN}}));
    check("reset_readdata", 64'(readdata), 64'h0);
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    int          k;
    logic [31:0] rnd;
    logic [31:0] d;
    logic [ADDR_W-1:0] a;
    int          op;

    idle(2);
    reset = 1'b0;
    read_all();

    // Raw digit write and readback.
    wr(4'd2, 32'h0000_0089);
    idle(2);
    rd(4'd2);
    idle(1);

    // Hex decode (raw behaviour when the decoder is not built).
    wr(4'd8, 32'h0000_003F);
    wr(4'd0, 32'h0000_008A);
    wr(4'd1, 32'h0000_0007);
    idle(2);
    rd(4'd8);
    rd(4'd0);
    wr(4'd8, 32'h0);

    // Blink on digit 0 with period 4; poll STATUS every cycle.
    wr(4'd0, 32'h0000_00C0);
    wr(4'd9, 32'h0000_0001);
    wr(4'd10, 32'd4);
    for (int i = 0; i < 20; i++) rd(4'd11);

    // Period 0 written while phase is 1.
    k = 0;
    while (!phase_after(m_cyc) && k < 50) begin
      idle(1);
      k++;
    end
    if (k >= 50) begin
      checks++;
      errors++;
      $display("FAIL phase_wait: phase still 0 after %0d cycles, required 1", k);
    end
    wr(4'd10, 32'd0);
    for (int i = 0; i < 6; i++) rd(4'd11);

    // Long period, then shortened at cnt=50.
    wr(4'd10, 32'd100);
    idle(50);
    wr(4'd10, 32'd2);
    for (int i = 0; i < 8; i++) rd(4'd11);

    // Unmapped addresses and field truncation.
    wr(4'd7, 32'hFFFF_FFFF);
    wr(4'd15, 32'hFFFF_FFFF);
    wr(4'd11, 32'hFFFF_FFFF);
    wr(4'd3, 32'hFFFF_FF5C);
    read_all();

    // Simultaneous read and write to the same address returns the old value.
    bus(1'b1, 1'b1, 1'b1, 4'd2, 32'h0000_005A);
    rd(4'd2);
    bus(1'b1, 1'b1, 1'b1, 4'd9, 32'h0000_002A);
    rd(4'd9);
    idle(2);

    // Reset mid-blink with digits loaded.
    for (int i = 0; i < NUM_DIGITS; i++) wr(ADDR_W'(i), 32'(8'h10 + i));
    wr(4'd9, 32'h3F);
    wr(4'd10, 32'd3);
    idle(7);
    do_reset();
    read_all();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      rnd = $urandom;
      a   = ADDR_W'($urandom_range(0, 15));
      d   = (a == 4'd10) ? {rnd[31:24], 24'($urandom_range(0, 7))} : rnd;
      op  = $urandom_range(0, 5);
      case (op)
        0:       bus(1'b0, 1'b0, 1'b0, a, d);
        1, 2:    wr(a, d);
        3:       rd(a);
        4:       bus(1'b1, 1'b1, 1'b1, a, d);
        default: bus(1'b0, 1'b1, 1'b1, a, d);
      endcase
    end

    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
